// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-bus load/store requests, aligns and
// extends load data, and drives mem-stage forwarding/writeback and stall signals.
module mem_stage #(
    parameter int XLEN          = 64,
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    input  logic                     mem_req_mem,
    input  logic                     mem_is_load,
    input  logic [4:0]               mem_l_mask,
    input  logic                     mem_is_store,
    input  logic [3:0]               mem_s_mask,
    input  logic [1:0]               mem_size,
    input  logic [XLEN-1:0]          mem_addr,
    input  logic [XLEN-1:0]          mem_alu_res,
    input  logic [XLEN-1:0]          mem_store_data,
    input  logic                     mem_req_rf_i,
    input  logic [RF_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                     dbus_req,
    output logic                     dbus_we,
    output logic [XLEN-1:0]          dbus_addr,
    output logic [XLEN-1:0]          dbus_wdata,
    output logic [7:0]               dbus_wstrb,
    output logic [1:0]               dbus_size,
    input  logic                     dbus_gnt,
    input  logic                     dbus_rvalid,
    input  logic [XLEN-1:0]          dbus_rdata,
    output logic                     mem_stall,
    output logic                     mem_req_rf,
    output logic [RF_ADDR_WIDTH-1:0] mem_fw_rd_addr,
    output logic [XLEN-1:0]          mem_fw_data,
    output logic                     mem_wb_valid,
    output logic                     mem_exp_flag
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state, state_n;
    logic [XLEN-1:0] load_data_q, load_ext, shifted;
    logic [7:0]      strb_base;
    logic [2:0]      off;
    logic            access, misalign, go, sgn;

    assign off    = mem_addr[2:0];
    assign access = mem_valid & mem_req_mem;

    always_comb begin
        misalign = 1'b0;
        case (mem_size)
            2'd1:    misalign = mem_addr[0];
            2'd2:    misalign = |mem_addr[1:0];
            2'd3:    misalign = |mem_addr[2:0];
            default: misalign = 1'b0;
        endcase
        misalign = misalign & access;
    end

    assign go = access & ~misalign;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (go) state_n = dbus_gnt ? (mem_is_load ? RESP : DONE) : REQ;
            REQ:  if (dbus_gnt) state_n = mem_is_load ? RESP : DONE;
            RESP: if (dbus_rvalid) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            load_data_q <= '0;
        end else begin
            state <= state_n;
            if (state == RESP && dbus_rvalid)
                load_data_q <= load_ext;
        end
    end

    // Request is only raised while waiting for a grant; inputs are held by the stall.
    assign dbus_req  = (state == IDLE && go) || (state == REQ);
    assign dbus_we   = mem_is_store;
    assign dbus_addr = mem_addr;
    assign dbus_size = mem_size;

    always_comb begin
        if (mem_s_mask[0])      dbus_wdata = {(XLEN/8){mem_store_data[7:0]}};
        else if (mem_s_mask[1]) dbus_wdata = {(XLEN/16){mem_store_data[15:0]}};
        else if (mem_s_mask[2]) dbus_wdata = {(XLEN/32){mem_store_data[31:0]}};
        else                    dbus_wdata = mem_store_data;
    end

    always_comb begin
        case (mem_size)
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

    assign dbus_wstrb = strb_base << off;

    // Beat is 8-byte aligned: move the addressed bytes to the bottom, then extend.
    assign shifted = dbus_rdata >> {off, 3'b000};
    assign sgn     = ~mem_l_mask[4];

    always_comb begin
        if (mem_l_mask[0])
            load_ext = {{(XLEN-8){sgn & shifted[7]}}, shifted[7:0]};
        else if (mem_l_mask[1])
            load_ext = {{(XLEN-16){sgn & shifted[15]}}, shifted[15:0]};
        else if (mem_l_mask[2])
            load_ext = {{(XLEN-32){sgn & shifted[31]}}, shifted[31:0]};
        else
            load_ext = shifted;
    end

    assign mem_stall      = go && (state != DONE);
    assign mem_wb_valid   = ~go || (state == DONE);
    assign mem_req_rf     = mem_valid & mem_req_rf_i & ~misalign;
    assign mem_fw_rd_addr = mem_rd_addr;
    assign mem_fw_data    = mem_is_load ? load_data_q : mem_alu_res;
    assign mem_exp_flag   = misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction-level model checked every cycle,
// plus literal expectations from hand-worked load/store scenarios.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, mem_req_mem, mem_is_load, mem_is_store, mem_req_rf_i;
    logic [4:0]  mem_l_mask;
    logic [3:0]  mem_s_mask;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr, mem_alu_res, mem_store_data;
    logic [4:0]  mem_rd_addr;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
    logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [7:0]  dbus_wstrb;
    logic [1:0]  dbus_size;
    logic        mem_stall, mem_req_rf, mem_wb_valid, mem_exp_flag;
    logic [4:0]  mem_fw_rd_addr;
    logic [63:0] mem_fw_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_req_mem(mem_req_mem), .mem_is_load(mem_is_load),
        .mem_l_mask(mem_l_mask), .mem_is_store(mem_is_store), .mem_s_mask(mem_s_mask),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_alu_res(mem_alu_res),
        .mem_store_data(mem_store_data), .mem_req_rf_i(mem_req_rf_i), .mem_rd_addr(mem_rd_addr),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_wstrb(dbus_wstrb), .dbus_size(dbus_size), .dbus_gnt(dbus_gnt),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .mem_stall(mem_stall), .mem_req_rf(mem_req_rf), .mem_fw_rd_addr(mem_fw_rd_addr),
        .mem_fw_data(mem_fw_data), .mem_wb_valid(mem_wb_valid), .mem_exp_flag(mem_exp_flag)
    );

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- transaction-level model ----------------
    bit          m_granted, m_done;
    logic [63:0] m_ldq;

    function automatic bit m_mis();
        int nb = 1 << mem_size;
        return mem_valid && mem_req_mem && ((mem_addr % nb) != 0);
    endfunction

    function automatic bit m_go();
        return mem_valid && mem_req_mem && !m_mis();
    endfunction

    function automatic logic [63:0] m_ext(logic [63:0] rd, logic [63:0] a, logic [4:0] lm);
        int nb = lm[0] ? 1 : lm[1] ? 2 : lm[2] ? 4 : 8;
        logic [63:0] v, mask;
        v = rd >> (int'(a[2:0]) * 8);
        mask = (nb == 8) ? '1 : ((64'd1 << (nb * 8)) - 64'd1);
        v = v & mask;
        if (!lm[4] && v[nb*8-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] m_wdata();
        int nb = mem_s_mask[0] ? 1 : mem_s_mask[1] ? 2 : mem_s_mask[2] ? 4 : 8;
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = mem_store_data[(i % nb)*8 +: 8];
        return w;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_granted = 0; m_done = 0; m_ldq = '0;
        end else if (m_done) begin
            m_done = 0; m_granted = 0;
        end else if (m_go() && !m_granted) begin
            if (dbus_gnt) begin
                m_granted = 1;
                if (!mem_is_load) m_done = 1;
            end
        end else if (m_granted && dbus_rvalid) begin
            m_ldq  = m_ext(dbus_rdata, mem_addr, mem_l_mask);
            m_done = 1;
        end
    end

    always @(negedge clk) begin
        automatic bit go = m_go();
        automatic int nb = 1 << mem_size;
        automatic logic [7:0] strb = 8'(((16'd1 << nb) - 16'd1) << mem_addr[2:0]);
        chk("m_req",    dbus_req,       go && !m_granted && !m_done);
        chk("m_we",     dbus_we,        mem_is_store);
        chk("m_addr",   dbus_addr,      mem_addr);
        chk("m_size",   dbus_size,      mem_size);
        chk("m_wstrb",  dbus_wstrb,     strb);
        chk("m_wdata",  dbus_wdata,     m_wdata());
        chk("m_stall",  mem_stall,      go && !m_done);
        chk("m_wbv",    mem_wb_valid,   !go || m_done);
        chk("m_exp",    mem_exp_flag,   m_mis());
        chk("m_reqrf",  mem_req_rf,     mem_valid && mem_req_rf_i && !m_mis());
        chk("m_rd",     mem_fw_rd_addr, mem_rd_addr);
        chk("m_fwdata", mem_fw_data,    mem_is_load ? m_ldq : mem_alu_res);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        mem_valid = 0; mem_req_mem = 0; mem_is_load = 0; mem_is_store = 0; mem_req_rf_i = 0;
        mem_l_mask = 0; mem_s_mask = 0; mem_size = 0; mem_addr = 0; mem_alu_res = 0;
        mem_store_data = 0; mem_rd_addr = 0; dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
    endtask

    task automatic load(logic [63:0] a, logic [1:0] sz, logic [4:0] lm);
        clr();
        mem_valid = 1; mem_req_mem = 1; mem_is_load = 1; mem_req_rf_i = 1; mem_rd_addr = 5'd5;
        mem_addr = a; mem_size = sz; mem_l_mask = lm;
    endtask

    initial begin
        rst_n = 0;
        clr();
        tick(); tick();
        @(negedge clk);
        chk("rst_req", dbus_req, 0);     chk("rst_stall", mem_stall, 0);
        chk("rst_reqrf", mem_req_rf, 0); chk("rst_wbv", mem_wb_valid, 1);
        chk("rst_exp", mem_exp_flag, 0);
        tick();
        rst_n = 1;

        // LW 0x1004, immediate grant, data next cycle
        load(64'h1004, 2'd2, 5'b00100); dbus_gnt = 1;
        @(negedge clk); chk("lw_c1_stall", mem_stall, 1); chk("lw_c1_req", dbus_req, 1);
        tick(); dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 64'h8000_0001_0000_0000;
        @(negedge clk); chk("lw_c2_stall", mem_stall, 1); chk("lw_c2_req", dbus_req, 0);
        tick(); dbus_rvalid = 0; dbus_rdata = 0;
        @(negedge clk);
        chk("lw_c3_stall", mem_stall, 0); chk("lw_c3_wbv", mem_wb_valid, 1);
        chk("lw_c3_reqrf", mem_req_rf, 1); chk("lw_data", mem_fw_data, 64'hFFFF_FFFF_8000_0001);
        tick();

        // LBU 0x1003 back-to-back
        load(64'h1003, 2'd0, 5'b10001); dbus_gnt = 1;
        tick(); dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 64'h0000_0000_AB00_0000;
        tick(); dbus_rvalid = 0;
        @(negedge clk); chk("lbu_data", mem_fw_data, 64'h0000_0000_0000_00AB);
        chk("lbu_wbv", mem_wb_valid, 1);
        tick();

        // LH 0x10, grant after 1 cycle, rvalid in grant cycle ignored, data 2 cycles later
        load(64'h10, 2'd1, 5'b00010);
        tick(); dbus_gnt = 1; dbus_rvalid = 1; dbus_rdata = 64'h1111_1111_1111_7777;
        tick(); dbus_gnt = 0; dbus_rvalid = 0;
        @(negedge clk); chk("lh_wait_stall", mem_stall, 1);
        tick(); dbus_rvalid = 1; dbus_rdata = 64'h0000_0000_0000_8001;
        tick(); dbus_rvalid = 0;
        @(negedge clk); chk("lh_data", mem_fw_data, 64'hFFFF_FFFF_FFFF_8001);
        tick();

        // SH 0x2006, grant after 3 cycles
        clr();
        mem_valid = 1; mem_req_mem = 1; mem_is_store = 1; mem_s_mask = 4'b0010;
        mem_size = 2'd1; mem_addr = 64'h2006; mem_store_data = 64'h1234;
        for (int c = 1; c <= 4; c++) begin
            dbus_gnt = (c == 4);
            @(negedge clk);
            chk("sh_req", dbus_req, 1); chk("sh_addr", dbus_addr, 64'h2006);
            chk("sh_stall", mem_stall, 1); chk("sh_wstrb", dbus_wstrb, 8'hC0);
            chk("sh_wdata", dbus_wdata, 64'h1234_1234_1234_1234);
            tick();
        end
        dbus_gnt = 0;
        @(negedge clk); chk("sh_done_stall", mem_stall, 0); chk("sh_done_wbv", mem_wb_valid, 1);
        chk("sh_done_req", dbus_req, 0);
        tick();

        // LD 0x3004 misaligned
        load(64'h3004, 2'd3, 5'b01000);
        @(negedge clk);
        chk("ld_mis_exp", mem_exp_flag, 1); chk("ld_mis_req", dbus_req, 0);
        chk("ld_mis_stall", mem_stall, 0);  chk("ld_mis_reqrf", mem_req_rf, 0);
        chk("ld_mis_wbv", mem_wb_valid, 1);
        tick();

        // ADD x7 = 0x55
        clr();
        mem_valid = 1; mem_req_rf_i = 1; mem_rd_addr = 5'd7; mem_alu_res = 64'h55;
        @(negedge clk);
        chk("add_data", mem_fw_data, 64'h55); chk("add_rd", mem_fw_rd_addr, 5'd7);
        chk("add_wbv", mem_wb_valid, 1);      chk("add_stall", mem_stall, 0);
        tick();

        // Reset while in RESP, then stray rvalid
        load(64'h8, 2'd2, 5'b00100); dbus_gnt = 1;
        tick(); dbus_gnt = 0;
        @(negedge clk); chk("rr_resp_stall", mem_stall, 1);
        rst_n = 0; mem_valid = 0;
        tick();
        rst_n = 1; dbus_rvalid = 1; dbus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk); chk("rr_stall", mem_stall, 0); chk("rr_q_cleared", mem_fw_data, 64'h0);
        tick(); dbus_rvalid = 0;
        @(negedge clk); chk("rr_no_capture", mem_fw_data, 64'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
